// File: rtl/regfile_write_scheduler.sv
// Register-file write-port arbiter (ALU vs. load) with a per-register
// outstanding-write scoreboard that drives the decode/issue stall.
module regfile_write_scheduler #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [2:0]  alu_rd,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_rd,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  input  logic        rsv_valid,
  input  logic [2:0]  rsv_rd,
  input  logic [2:0]  src_ra,
  input  logic [2:0]  src_rb,
  output logic        stall,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [7:0]  busy_mask,
  output logic        err
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic {GrantAlu = 1'b0, GrantMem = 1'b1} grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q [8];
  logic [CNT_W-1:0]  cnt_d [8];
  logic              err_q, err_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;

  logic              alu_gnt, mem_gnt, xfer;
  logic [2:0]        xfer_rd;
  logic [15:0]       xfer_data;
  logic [7:0]        inc_vec, dec_vec;

  // Round-robin: under contention the side that lost last time wins.
  always_comb begin
    alu_gnt = alu_valid && (!mem_valid || (last_grant_q == GrantMem));
    mem_gnt = mem_valid && (!alu_valid || (last_grant_q == GrantAlu));
    xfer    = alu_gnt || mem_gnt;
    xfer_rd   = alu_gnt ? alu_rd   : mem_rd;
    xfer_data = alu_gnt ? alu_data : mem_data;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      busy_mask[n] = (cnt_q[n] != '0);
    end
  end

  assign stall = busy_mask[src_ra] | busy_mask[src_rb] |
                 (rsv_valid && (rsv_rd != 3'd0) && (cnt_q[rsv_rd] == CntMax));

  always_comb begin
    inc_vec = (rsv_valid && !stall) ? (8'b1 << rsv_rd) : 8'b0;
    dec_vec = xfer ? (8'b1 << xfer_rd) : 8'b0;
    inc_vec[0] = 1'b0;
    dec_vec[0] = 1'b0;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    err_d        = err_q;
    wr_en_d      = xfer && (xfer_rd != 3'd0);
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    for (int n = 0; n < 8; n++) begin
      cnt_d[n] = cnt_q[n];
    end
    if (alu_valid && mem_valid) begin
      last_grant_d = alu_gnt ? GrantAlu : GrantMem;
    end
    if (wr_en_d) begin
      wr_addr_d = xfer_rd;
      wr_data_d = xfer_data;
    end
    cnt_d[0] = '0;
    for (int n = 1; n < 8; n++) begin
      if (inc_vec[n] && !dec_vec[n]) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end else if (dec_vec[n] && !inc_vec[n]) begin
        // Underflow saturates at zero and latches the error flag.
        if (cnt_q[n] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[n] = cnt_q[n] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GrantMem;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 3'd0;
      wr_data_q    <= 16'd0;
      for (int n = 0; n < 8; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      for (int n = 0; n < 8; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign err     = err_q;

endmodule

// File: doc/regfile_write_scheduler.md
REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: alu_valid in 1, alu_rd in 3, alu_data in 16, alu_ready out 1 (ALU write-back requester).
REQ-004 SHALL have ports: mem_valid in 1, mem_rd in 3, mem_data in 16, mem_ready out 1 (load write-back requester).
REQ-005 SHALL have ports: rsv_valid in 1, rsv_rd in 3 (issue stage reserves destination register).
REQ-006 SHALL have ports: src_ra in 3, src_rb in 3 (source registers of instruction in decode).
REQ-007 SHALL have ports: stall out 1 (hold decode/issue).
REQ-008 SHALL have ports: wr_en out 1, wr_addr out 3, wr_data out 16 (drive register-file enableWrite/RW/BusW).
REQ-009 SHALL have ports: busy_mask out 8 (bit n = R n has outstanding write), err out 1 (sticky scoreboard underflow).
REQ-010 SHALL have parameter CNT_W, default 2, width of per-register outstanding-write counter.

Function
REQ-011 SHALL share the single register-file write port between ALU and MEM requesters, at most one grant per cycle.
REQ-012 Only one valid -> that requester granted; both valid -> grant the one not granted at last contention (round-robin pointer last_grant).
REQ-013 last_grant SHALL update only on a contended cycle (both valid).
REQ-014 x_ready SHALL be combinational, asserted in the same cycle as grant; transfer occurs on edge where x_valid && x_ready.
REQ-015 Requester SHALL hold valid, rd, data stable until ready; the scheduler never drops a presented request.
REQ-016 Latency: wr_en/wr_addr/wr_data SHALL be registered, asserted exactly one cycle after the transfer edge, for exactly one cycle per transfer.
REQ-017 Transfer with rd==0: handshake completes, wr_en stays 0 (R0 is never written), no counter change.
REQ-018 Cycles with no transfer: wr_en=0; wr_addr/wr_data hold previous values.
REQ-019 Scoreboard: one CNT_W-bit counter per register R1..R7; R0 counter constant 0.
REQ-020 Increment on edge where rsv_valid && rsv_rd!=0 && !stall; decrement on edge of a transfer with that rd.
REQ-021 Simultaneous increment and decrement of the same register SHALL leave the counter unchanged.
REQ-022 Decrement of a zero counter SHALL leave it 0 and set err; err clears only on reset.
REQ-023 busy_mask[n] SHALL equal (counter[n]!=0), registered state only.
REQ-024 stall SHALL be combinational: busy_mask[src_ra] | busy_mask[src_rb] | (rsv_valid && rsv_rd!=0 && counter[rsv_rd]==max).
REQ-025 No bypass: stall on a source deasserts in the cycle wr_en for the final outstanding write is high.
REQ-026 When stall=1 reservation SHALL be ignored; write-back arbitration continues unaffected by stall.

Reset
REQ-027 On reset edge: all counters 0, busy_mask 0, wr_en 0, wr_addr 0, wr_data 0, err 0, last_grant=MEM (ALU wins first contention).
REQ-028 Reset SHALL override any simultaneous transfer or reservation; in-flight writes are discarded, no wr_en in cycle after reset.
REQ-029 Ready outputs SHALL remain combinational functions of valid inputs and last_grant during reset.

Verification
REQ-030 Single ALU write: alu_valid=1, rd=3, data=16'h1234 -> alu_ready same cycle; next cycle wr_en=1, wr_addr=3, wr_data=16'h1234; one cycle only.
REQ-031 Contention: both valid continuously, ALU rd=1, MEM rd=2, after reset -> grants ALU, MEM, ALU, MEM; wr_addr sequence 1,2,1,2.
REQ-032 Hazard: reserve rd=5; next cycle src_ra=5 -> stall=1; MEM writes rd=5 -> stall=0 in cycle wr_en high; busy_mask[5]=0.
REQ-033 Saturation (CNT_W=2): reserve R4 three times -> fourth rsv_valid rd=4 stalls, counter stays 3; simultaneous reserve+write R4 -> counter unchanged.
REQ-034 R0/underflow: write rd=0 -> handshake, wr_en=0; write rd=6 with counter 0 -> err=1, counter 0.
REQ-035 Reset mid-operation: reserve R2, assert reset during ALU transfer -> busy_mask=0, wr_en=0 next cycle, err=0.
